// File: rtl/opl3_timer_bank_if.sv
// Register-file side bundle for the OPL3 timer bank: per-timer controls in,
// overflow pulses, sticky flags, IRQ and counter readback out.
interface opl3_timer_bank_if #(
    parameter int NUM_TIMERS  = 2,
    parameter int TIMER_WIDTH = 8
);
    logic [NUM_TIMERS*TIMER_WIDTH-1:0] timer_preset;
    logic [NUM_TIMERS-1:0]             start_timer;
    logic [NUM_TIMERS-1:0]             mask;
    logic                              irq_reset;
    logic [NUM_TIMERS-1:0]             timer_overflow_pulse;
    logic [NUM_TIMERS-1:0]             timer_flag;
    logic                              irq;
    logic [NUM_TIMERS*TIMER_WIDTH-1:0] timer_value;

    modport master (
        output timer_preset, start_timer, mask, irq_reset,
        input  timer_overflow_pulse, timer_flag, irq, timer_value
    );

    modport slave (
        input  timer_preset, start_timer, mask, irq_reset,
        output timer_overflow_pulse, timer_flag, irq, timer_value
    );
endinterface

// File: rtl/opl3_timer_bank.sv
// Bank of independent OPL3-style up-counting interval timers sharing one
// sticky flag / IRQ block with register-0x04 style IRQ-reset semantics.
module opl3_timer_bank #(
    parameter int NUM_TIMERS     = 2,
    parameter int TIMER_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter logic [NUM_TIMERS*PRESCALE_WIDTH-1:0] TICK_CYCLES = {16'd4073, 16'd1018}
) (
    input  logic               clk,
    input  logic               reset_n,
    opl3_timer_bank_if.slave   bus
);

    localparam logic [TIMER_WIDTH-1:0]    CNT_ONES  = '1;
    localparam logic [TIMER_WIDTH-1:0]    CNT_ONE   = TIMER_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = PRESCALE_WIDTH'(1);

    logic [NUM_TIMERS-1:0]     start_q;
    logic [PRESCALE_WIDTH-1:0] presc_q    [NUM_TIMERS];
    logic [PRESCALE_WIDTH-1:0] presc_next [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0]    cnt_q      [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0]    cnt_next   [NUM_TIMERS];
    logic [PRESCALE_WIDTH-1:0] tick_limit [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0]    preset     [NUM_TIMERS];

    logic [NUM_TIMERS-1:0] rise;
    logic [NUM_TIMERS-1:0] tick;
    logic [NUM_TIMERS-1:0] ovf;
    logic [NUM_TIMERS-1:0] flag_next;
    logic [NUM_TIMERS-1:0] pulse_q;
    logic [NUM_TIMERS-1:0] flag_q;
    logic                  irq_q;
    logic [NUM_TIMERS*TIMER_WIDTH-1:0] value_packed;

    // A rising start edge restarts the channel and suppresses any tick that
    // cycle, so accumulated prescale phase from before a stop is discarded.
    always_comb begin
        rise      = '0;
        tick      = '0;
        ovf       = '0;
        flag_next = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            tick_limit[i] = TICK_CYCLES[i*PRESCALE_WIDTH +: PRESCALE_WIDTH] - PRESC_ONE;
            preset[i]     = bus.timer_preset[i*TIMER_WIDTH +: TIMER_WIDTH];
            presc_next[i] = presc_q[i];
            cnt_next[i]   = cnt_q[i];

            rise[i] = bus.start_timer[i] & ~start_q[i];
            tick[i] = bus.start_timer[i] & ~rise[i] & (presc_q[i] == tick_limit[i]);
            ovf[i]  = tick[i] & (cnt_q[i] == CNT_ONES);

            if (rise[i]) begin
                presc_next[i] = '0;
                cnt_next[i]   = preset[i];
            end else if (bus.start_timer[i]) begin
                presc_next[i] = tick[i] ? '0 : presc_q[i] + PRESC_ONE;
                if (tick[i]) begin
                    cnt_next[i] = (cnt_q[i] == CNT_ONES) ? preset[i] : cnt_q[i] + CNT_ONE;
                end
            end

            // A new overflow outranks a coincident irq_reset so no event is lost.
            flag_next[i] = (flag_q[i] & ~bus.irq_reset) | (ovf[i] & ~bus.mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                presc_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            start_q <= bus.start_timer;
            pulse_q <= ovf;
            flag_q  <= flag_next;
            irq_q   <= |flag_next;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                presc_q[i] <= presc_next[i];
                cnt_q[i]   <= cnt_next[i];
            end
        end
    end

    always_comb begin
        value_packed = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            value_packed[i*TIMER_WIDTH +: TIMER_WIDTH] = cnt_q[i];
        end
    end

    assign bus.timer_overflow_pulse = pulse_q;
    assign bus.timer_flag           = flag_q;
    assign bus.irq                  = irq_q;
    assign bus.timer_value          = value_packed;

endmodule

// File: tb/tb_opl3_timer_bank.sv
// Directed bench for opl3_timer_bank with two channels: timer 0 ticks every
// 4 clocks, timer 1 every 8 clocks; expected values are hand-computed per edge.
module tb_opl3_timer_bank;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    opl3_timer_bank_if #(.NUM_TIMERS(2), .TIMER_WIDTH(8)) bus ();

    opl3_timer_bank #(
        .NUM_TIMERS(2),
        .TIMER_WIDTH(8),
        .PRESCALE_WIDTH(16),
        .TICK_CYCLES({16'd8, 16'd4})
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic [1:0] start, input logic [1:0] msk,
                                 input logic [15:0] preset, input logic irqr);
        reset_n          = rn;
        bus.start_timer  = start;
        bus.mask         = msk;
        bus.timer_preset = preset;
        bus.irq_reset    = irqr;
    endtask

    // Advance n active edges and settle just after the last one.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, "_pulse"}, 32'(bus.timer_overflow_pulse), 32'h0);
        checkOutput({tag, "_flag"},  32'(bus.timer_flag), 32'h0);
        checkOutput({tag, "_irq"},   32'(bus.irq), 32'h0);
        checkOutput({tag, "_value"}, 32'(bus.timer_value), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset and idle
        applyStimulus(1'b0, 2'b00, 2'b00, 16'hFFFE, 1'b0);
        stepCycles(3);
        checkAllIdle("reset");
        applyStimulus(1'b1, 2'b00, 2'b00, 16'hFFFE, 1'b0);
        for (int i = 0; i < 50; i++) begin
            stepCycles(1);
            checkAllIdle("idle");
        end

        // Basic overflow on timer 0, preset 0xFE, rise at edge E0
        applyStimulus(1'b1, 2'b01, 2'b00, 16'hFFFE, 1'b0);
        stepCycles(1);
        checkOutput("e0_value0", 32'(bus.timer_value[7:0]), 32'hFE);
        checkOutput("e0_pulse", 32'(bus.timer_overflow_pulse), 32'h0);
        stepCycles(3);
        checkOutput("e3_value0", 32'(bus.timer_value[7:0]), 32'hFE);
        stepCycles(1);
        checkOutput("e4_value0", 32'(bus.timer_value[7:0]), 32'hFF);
        stepCycles(3);
        checkOutput("e7_pulse", 32'(bus.timer_overflow_pulse), 32'h0);
        checkOutput("e7_flag", 32'(bus.timer_flag), 32'h0);
        stepCycles(1);
        checkOutput("e8_pulse", 32'(bus.timer_overflow_pulse), 32'h1);
        checkOutput("e8_flag", 32'(bus.timer_flag), 32'h1);
        checkOutput("e8_irq", 32'(bus.irq), 32'h1);
        checkOutput("e8_value0", 32'(bus.timer_value[7:0]), 32'hFE);
        stepCycles(1);
        checkOutput("e9_pulse", 32'(bus.timer_overflow_pulse), 32'h0);
        checkOutput("e9_flag", 32'(bus.timer_flag), 32'h1);
        stepCycles(6);
        checkOutput("e15_pulse", 32'(bus.timer_overflow_pulse), 32'h0);
        stepCycles(1);
        checkOutput("e16_pulse", 32'(bus.timer_overflow_pulse), 32'h1);
        applyStimulus(1'b1, 2'b01, 2'b00, 16'hFFFE, 1'b1);
        stepCycles(1);
        checkOutput("e17_flag_cleared", 32'(bus.timer_flag), 32'h0);
        checkOutput("e17_irq_cleared", 32'(bus.irq), 32'h0);

        // Stop timer 0 mid-count, then restart with a different preset
        applyStimulus(1'b1, 2'b00, 2'b00, 16'hFFFE, 1'b0);
        for (int i = 0; i < 20; i++) begin
            stepCycles(1);
            checkOutput("stop_value0", 32'(bus.timer_value[7:0]), 32'hFE);
            checkOutput("stop_pulse", 32'(bus.timer_overflow_pulse), 32'h0);
        end
        applyStimulus(1'b1, 2'b01, 2'b00, 16'hFFF0, 1'b0);
        stepCycles(1);
        checkOutput("f0_reload", 32'(bus.timer_value[7:0]), 32'hF0);
        stepCycles(3);
        checkOutput("f3_no_tick", 32'(bus.timer_value[7:0]), 32'hF0);
        stepCycles(1);
        checkOutput("f4_first_tick", 32'(bus.timer_value[7:0]), 32'hF1);

        // Preset change while running
        applyStimulus(1'b0, 2'b00, 2'b00, 16'hFFFE, 1'b0);
        stepCycles(2);
        applyStimulus(1'b1, 2'b01, 2'b00, 16'hFFFE, 1'b0);
        stepCycles(1);
        checkOutput("g0_value0", 32'(bus.timer_value[7:0]), 32'hFE);
        stepCycles(8);
        checkOutput("g8_pulse", 32'(bus.timer_overflow_pulse), 32'h1);
        stepCycles(1);
        applyStimulus(1'b1, 2'b01, 2'b00, 16'hFFFC, 1'b0);
        stepCycles(3);
        checkOutput("g12_value0", 32'(bus.timer_value[7:0]), 32'hFF);
        stepCycles(4);
        checkOutput("g16_pulse", 32'(bus.timer_overflow_pulse), 32'h1);
        checkOutput("g16_new_preset", 32'(bus.timer_value[7:0]), 32'hFC);
        stepCycles(15);
        checkOutput("g31_pulse", 32'(bus.timer_overflow_pulse), 32'h0);
        stepCycles(1);
        checkOutput("g32_pulse", 32'(bus.timer_overflow_pulse), 32'h1);

        // Mask and IRQ reset on timer 1, preset 0xFF so every tick overflows
        applyStimulus(1'b0, 2'b00, 2'b00, 16'hFFFC, 1'b0);
        stepCycles(2);
        applyStimulus(1'b1, 2'b10, 2'b10, 16'hFFFC, 1'b0);
        stepCycles(1);
        checkOutput("h0_value1", 32'(bus.timer_value[15:8]), 32'hFF);
        stepCycles(7);
        checkOutput("h7_pulse", 32'(bus.timer_overflow_pulse), 32'h0);
        stepCycles(1);
        checkOutput("h8_pulse", 32'(bus.timer_overflow_pulse), 32'h2);
        checkOutput("h8_masked_flag", 32'(bus.timer_flag), 32'h0);
        checkOutput("h8_masked_irq", 32'(bus.irq), 32'h0);
        applyStimulus(1'b1, 2'b10, 2'b00, 16'hFFFC, 1'b0);
        stepCycles(8);
        checkOutput("h16_pulse", 32'(bus.timer_overflow_pulse), 32'h2);
        checkOutput("h16_flag", 32'(bus.timer_flag), 32'h2);
        checkOutput("h16_irq", 32'(bus.irq), 32'h1);
        applyStimulus(1'b1, 2'b10, 2'b00, 16'hFFFC, 1'b1);
        stepCycles(1);
        checkOutput("h17_flag", 32'(bus.timer_flag), 32'h0);
        checkOutput("h17_irq", 32'(bus.irq), 32'h0);
        applyStimulus(1'b1, 2'b10, 2'b00, 16'hFFFC, 1'b0);
        stepCycles(6);
        applyStimulus(1'b1, 2'b10, 2'b00, 16'hFFFC, 1'b1);
        stepCycles(1);
        checkOutput("h24_set_wins_flag", 32'(bus.timer_flag), 32'h2);
        checkOutput("h24_set_wins_irq", 32'(bus.irq), 32'h1);
        applyStimulus(1'b1, 2'b10, 2'b00, 16'hFFFC, 1'b0);
        stepCycles(1);
        checkOutput("h25_sticky", 32'(bus.timer_flag), 32'h2);
        applyStimulus(1'b1, 2'b10, 2'b10, 16'hFFFC, 1'b0);
        stepCycles(1);
        checkOutput("h26_mask_keeps_flag", 32'(bus.timer_flag), 32'h2);
        checkOutput("h26_irq", 32'(bus.irq), 32'h1);

        // Both timers running, then reset mid-operation with start held high
        applyStimulus(1'b1, 2'b11, 2'b10, 16'hFFFE, 1'b0);
        stepCycles(1);
        checkOutput("h27_value0", 32'(bus.timer_value[7:0]), 32'hFE);
        stepCycles(8);
        checkOutput("h35_pulse", 32'(bus.timer_overflow_pulse), 32'h1);
        checkOutput("h35_flags", 32'(bus.timer_flag), 32'h3);
        applyStimulus(1'b0, 2'b11, 2'b10, 16'hFFFE, 1'b0);
        stepCycles(1);
        checkAllIdle("midreset");
        applyStimulus(1'b1, 2'b11, 2'b10, 16'hFFFE, 1'b0);
        stepCycles(1);
        checkOutput("post_reset_reload", 32'(bus.timer_value), 32'hFFFE);
        checkOutput("post_reset_flag", 32'(bus.timer_flag), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
